// File: rtl/vita49_pkg.sv
// Shared definitions for the multi-channel VITA49 packetiser: FSM encoding,
// header field constants and header-word builder.
package vita49_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_HDR     = 4'd1,
      ST_SID     = 4'd2,
      ST_TSI     = 4'd3,
      ST_TSF_HI  = 4'd4,
      ST_TSF_LO  = 4'd5,
      ST_PAYLOAD = 4'd6,
      ST_PAD     = 4'd7,
      ST_TRL     = 4'd8
   } state_t;

   localparam logic [3:0] PKT_TYPE  = 4'b0001;
   localparam logic [1:0] TSI_UTC   = 2'b01;
   localparam logic [1:0] TSF_REAL  = 2'b10;
   localparam int         HDR_WORDS = 5;

   function automatic logic [31:0] mk_hdr(input logic       trl_en,
                                          input logic [3:0]  pcnt,
                                          input logic [15:0] size);
      return {PKT_TYPE, 1'b0, trl_en, 2'b00, TSI_UTC, TSF_REAL, pcnt, size};
   endfunction

endpackage

// File: rtl/vita49_rr_arb.sv
// Round-robin arbiter: one-hot grant searching from the rotation pointer,
// pointer moves to the granted channel + 1 when advance is asserted.
module vita49_rr_arb #(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant,
   output logic [2:0]        grant_idx
);

   logic [2:0] ptr;
   logic       found;

   // Two passes: channels at or above the pointer first, then the wrap-around.
   always_comb begin
      grant     = '0;
      grant_idx = 3'd0;
      found     = 1'b0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (!found && req[j] && (3'(j) >= ptr)) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = 3'(j);
         end
      end
      for (int j = 0; j < NUM_CH; j++) begin
         if (!found && req[j] && (3'(j) < ptr)) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = 3'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 3'd0;
      else if (advance)
         ptr <= (grant_idx == 3'(NUM_CH - 1)) ? 3'd0 : grant_idx + 3'd1;
   end

endmodule

// File: rtl/vita49_pack_mc.sv
// Multi-channel VITA49 IF-data packetiser: round-robin channel selection,
// five-word header prefix, pass-through payload with zero padding on short input.
module vita49_pack_mc
   import vita49_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
) (
   input  logic                  AXIS_ACLK,
   input  logic                  AXIS_ARESETN,
   input  logic [NUM_CH*32-1:0]  S_AXIS_TDATA,
   input  logic [NUM_CH-1:0]     S_AXIS_TVALID,
   input  logic [NUM_CH-1:0]     S_AXIS_TLAST,
   output logic [NUM_CH-1:0]     S_AXIS_TREADY,
   output logic [31:0]           M_AXIS_TDATA,
   output logic                  M_AXIS_TVALID,
   output logic                  M_AXIS_TLAST,
   input  logic                  M_AXIS_TREADY,
   input  logic [NUM_CH-1:0]     ch_enable,
   input  logic [NUM_CH*32-1:0]  stream_id,
   input  logic [CNT_W-1:0]      pkt_size,
   input  logic                  trailer_en,
   input  logic [31:0]           trailer,
   input  logic [31:0]           timestamp_sec,
   input  logic [63:0]           timestamp_fsec,
   input  logic                  err_clr,
   output logic [NUM_CH-1:0]     err_short,
   output logic                  err_cfg,
   output logic [3:0]            state_dbg,
   output logic [2:0]            active_ch_dbg
);

   state_t            state, state_nxt;
   logic [2:0]        ch;
   logic [31:0]       sid_q, trl_q, sec_q, sid_g;
   logic [63:0]       fsec_q;
   logic [CNT_W-1:0]  size_q, cnt;
   logic              trl_en_q;
   logic [3:0]        pcnt [NUM_CH];
   logic [NUM_CH-1:0] req, grant, short_set;
   logic [2:0]        grant_idx;
   logic [31:0]       s_dat;
   logic              s_vld, s_last;
   logic [3:0]        s_pcnt;
   logic [15:0]       size_fld;
   logic              any_req, cfg_bad, start, last_word, s_hs, pad_hs, out_hs;

   assign req       = ch_enable & S_AXIS_TVALID;
   assign any_req   = |req;
   assign cfg_bad   = (pkt_size == '0);
   assign start     = (state == ST_IDLE) && any_req;
   assign last_word = (cnt == size_q - CNT_W'(1));
   assign s_hs      = (state == ST_PAYLOAD) && s_vld && M_AXIS_TREADY;
   assign pad_hs    = (state == ST_PAD) && M_AXIS_TREADY;
   assign out_hs    = M_AXIS_TVALID && M_AXIS_TREADY;
   assign size_fld  = 16'(HDR_WORDS + int'(size_q) + int'(trl_en_q));

   assign state_dbg     = state;
   assign active_ch_dbg = ch;

   vita49_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .clk       (AXIS_ACLK),
      .rst_n     (AXIS_ARESETN),
      .req       (req),
      .advance   (start),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sid_g = '0;
      for (int j = 0; j < NUM_CH; j++)
         if (grant[j]) sid_g = stream_id[32*j +: 32];
   end

   always_comb begin
      s_dat     = '0;
      s_vld     = 1'b0;
      s_last    = 1'b0;
      s_pcnt    = '0;
      short_set = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (ch == 3'(j)) begin
            s_dat  = S_AXIS_TDATA[32*j +: 32];
            s_vld  = S_AXIS_TVALID[j];
            s_last = S_AXIS_TLAST[j];
            s_pcnt = pcnt[j];
            short_set[j] = s_hs && s_last && !last_word;
         end
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (any_req && !cfg_bad) state_nxt = ST_HDR;
         ST_HDR:     if (M_AXIS_TREADY) state_nxt = ST_SID;
         ST_SID:     if (M_AXIS_TREADY) state_nxt = ST_TSI;
         ST_TSI:     if (M_AXIS_TREADY) state_nxt = ST_TSF_HI;
         ST_TSF_HI:  if (M_AXIS_TREADY) state_nxt = ST_TSF_LO;
         ST_TSF_LO:  if (M_AXIS_TREADY) state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: begin
            if (s_hs && last_word)
               state_nxt = trl_en_q ? ST_TRL : ST_IDLE;
            else if (s_hs && s_last)
               state_nxt = ST_PAD;
         end
         ST_PAD:     if (pad_hs && last_word) state_nxt = trl_en_q ? ST_TRL : ST_IDLE;
         ST_TRL:     if (M_AXIS_TREADY) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      M_AXIS_TDATA  = '0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TLAST  = 1'b0;
      S_AXIS_TREADY = '0;
      unique case (state)
         ST_IDLE:    ;
         ST_HDR:     begin M_AXIS_TVALID = 1'b1; M_AXIS_TDATA = mk_hdr(trl_en_q, s_pcnt, size_fld); end
         ST_SID:     begin M_AXIS_TVALID = 1'b1; M_AXIS_TDATA = sid_q; end
         ST_TSI:     begin M_AXIS_TVALID = 1'b1; M_AXIS_TDATA = sec_q; end
         ST_TSF_HI:  begin M_AXIS_TVALID = 1'b1; M_AXIS_TDATA = fsec_q[63:32]; end
         ST_TSF_LO:  begin M_AXIS_TVALID = 1'b1; M_AXIS_TDATA = fsec_q[31:0]; end
         ST_PAYLOAD: begin
            M_AXIS_TVALID = s_vld;
            M_AXIS_TDATA  = s_dat;
            M_AXIS_TLAST  = last_word && !trl_en_q;
            for (int j = 0; j < NUM_CH; j++)
               S_AXIS_TREADY[j] = (ch == 3'(j)) && M_AXIS_TREADY;
         end
         ST_PAD:     begin M_AXIS_TVALID = 1'b1; M_AXIS_TLAST = last_word && !trl_en_q; end
         ST_TRL:     begin M_AXIS_TVALID = 1'b1; M_AXIS_TLAST = 1'b1; M_AXIS_TDATA = trl_q; end
         default:    ;
      endcase
   end

   // Packet context is captured once at grant so live input changes cannot tear a packet.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         ch       <= '0;
         sid_q    <= '0;
         trl_q    <= '0;
         sec_q    <= '0;
         fsec_q   <= '0;
         size_q   <= '0;
         trl_en_q <= 1'b0;
         cnt      <= '0;
      end else if (start && !cfg_bad) begin
         ch       <= grant_idx;
         sid_q    <= sid_g;
         trl_q    <= trailer;
         sec_q    <= timestamp_sec;
         fsec_q   <= timestamp_fsec;
         size_q   <= pkt_size;
         trl_en_q <= trailer_en;
         cnt      <= '0;
      end else if (s_hs || pad_hs) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         for (int j = 0; j < NUM_CH; j++) pcnt[j] <= 4'd0;
      end else if (out_hs && M_AXIS_TLAST) begin
         for (int j = 0; j < NUM_CH; j++)
            if (ch == 3'(j)) pcnt[j] <= pcnt[j] + 4'd1;
      end
   end

   // A new error in the same cycle as err_clr still leaves its bit set.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         err_short <= '0;
         err_cfg   <= 1'b0;
      end else begin
         err_short <= (err_clr ? '0 : err_short) | short_set;
         err_cfg   <= (err_clr ? 1'b0 : err_cfg) | (start && cfg_bad);
      end
   end

endmodule

// File: tb/tb_vita49_pack_mc.sv
// Scoreboard bench for vita49_pack_mc: directed packets push expected words,
// an independent monitor pops and compares on every output handshake.
module tb_vita49_pack_mc;

   logic        AXIS_ACLK = 1'b0;
   logic        AXIS_ARESETN;
   logic [63:0] S_AXIS_TDATA;
   logic [1:0]  S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
   logic [1:0]  ch_enable;
   logic [63:0] stream_id;
   logic [15:0] pkt_size;
   logic        trailer_en;
   logic [31:0] trailer, timestamp_sec;
   logic [63:0] timestamp_fsec;
   logic        err_clr;
   logic [1:0]  err_short;
   logic        err_cfg;
   logic [3:0]  state_dbg;
   logic [2:0]  active_ch_dbg;

   logic [32:0] src_q0[$], src_q1[$], exp_q[$];
   logic [1:0]  drv_hs;
   logic [32:0] w0, w1;
   bit          rand_rdy = 1'b0, stall = 1'b0;
   int          errors = 0, checks = 0;

   localparam logic [31:0] SID0 = 32'h5A00_0000, SID1 = 32'h5A00_0001;

   always #5 AXIS_ACLK = ~AXIS_ACLK;

   vita49_pack_mc #(.NUM_CH(2), .CNT_W(16)) dut (
      .AXIS_ACLK      (AXIS_ACLK),
      .AXIS_ARESETN   (AXIS_ARESETN),
      .S_AXIS_TDATA   (S_AXIS_TDATA),
      .S_AXIS_TVALID  (S_AXIS_TVALID),
      .S_AXIS_TLAST   (S_AXIS_TLAST),
      .S_AXIS_TREADY  (S_AXIS_TREADY),
      .M_AXIS_TDATA   (M_AXIS_TDATA),
      .M_AXIS_TVALID  (M_AXIS_TVALID),
      .M_AXIS_TLAST   (M_AXIS_TLAST),
      .M_AXIS_TREADY  (M_AXIS_TREADY),
      .ch_enable      (ch_enable),
      .stream_id      (stream_id),
      .pkt_size       (pkt_size),
      .trailer_en     (trailer_en),
      .trailer        (trailer),
      .timestamp_sec  (timestamp_sec),
      .timestamp_fsec (timestamp_fsec),
      .err_clr        (err_clr),
      .err_short      (err_short),
      .err_cfg        (err_cfg),
      .state_dbg      (state_dbg),
      .active_ch_dbg  (active_ch_dbg)
   );

   task automatic tick();
      @(posedge AXIS_ACLK);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ex(input logic [31:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic exp_hdr5(input logic [31:0] h, input logic [31:0] sid,
                           input logic [31:0] sec, input logic [63:0] fsec);
      ex(h, 1'b0);
      ex(sid, 1'b0);
      ex(sec, 1'b0);
      ex(fsec[63:32], 1'b0);
      ex(fsec[31:0], 1'b0);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || state_dbg != 4'd0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || state_dbg != 4'd0) begin
         errors++;
         $display("FAIL %s: timeout with %0d words outstanding, state %0d, need 0 and idle",
                  name, exp_q.size(), state_dbg);
         exp_q.delete();
      end
   endtask

   // Source driver: AXIS-compliant per-channel queues plus master ready control.
   initial begin
      S_AXIS_TVALID = '0;
      S_AXIS_TDATA  = '0;
      S_AXIS_TLAST  = '0;
      M_AXIS_TREADY = 1'b1;
      forever begin
         @(negedge AXIS_ACLK);
         drv_hs = S_AXIS_TVALID & S_AXIS_TREADY;
         @(posedge AXIS_ACLK);
         #1;
         if (drv_hs[0] && src_q0.size() != 0) void'(src_q0.pop_front());
         if (drv_hs[1] && src_q1.size() != 0) void'(src_q1.pop_front());
         w0 = (src_q0.size() != 0) ? src_q0[0] : 33'h0;
         w1 = (src_q1.size() != 0) ? src_q1[0] : 33'h0;
         S_AXIS_TVALID = {src_q1.size() != 0, src_q0.size() != 0};
         S_AXIS_TDATA  = {w1[31:0], w0[31:0]};
         S_AXIS_TLAST  = {w1[32], w0[32]};
         M_AXIS_TREADY = stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   initial begin
      logic        held;
      logic [31:0] hd;
      logic [32:0] e;
      held = 1'b0;
      hd   = '0;
      forever begin
         @(negedge AXIS_ACLK);
         if (AXIS_ARESETN !== 1'b1) begin
            held = 1'b0;
            continue;
         end
         if (held) begin
            checks++;
            if (!(M_AXIS_TVALID === 1'b1 && M_AXIS_TDATA === hd)) begin
               errors++;
               $display("FAIL stall_hold: got vld=%b data=%h expected vld=1 data=%h",
                        M_AXIS_TVALID, M_AXIS_TDATA, hd);
            end
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_word: got unexpected last=%b data=%h, expected none",
                        M_AXIS_TLAST, M_AXIS_TDATA);
            end else begin
               e = exp_q.pop_front();
               if ({M_AXIS_TLAST, M_AXIS_TDATA} !== e) begin
                  errors++;
                  $display("FAIL out_word: got last=%b data=%h expected last=%b data=%h",
                           M_AXIS_TLAST, M_AXIS_TDATA, e[32], e[31:0]);
               end
            end
            held = 1'b0;
         end else if (M_AXIS_TVALID) begin
            held = 1'b1;
            hd   = M_AXIS_TDATA;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      AXIS_ARESETN   = 1'b0;
      ch_enable      = 2'b00;
      stream_id      = {SID1, SID0};
      pkt_size       = 16'd4;
      trailer_en     = 1'b0;
      trailer        = 32'hDEAD_BEEF;
      timestamp_sec  = 32'h11;
      timestamp_fsec = 64'h2233;
      err_clr        = 1'b0;
      for (int k = 0; k < 4; k++) src_q0.push_back({1'(k == 3), 32'hC000_0000 + 32'(k)});
      repeat (3) tick();

      // Reset state with a valid source present
      chk("rst_s_tready", S_AXIS_TREADY, 0);
      chk("rst_m_tvalid", M_AXIS_TVALID, 0);
      chk("rst_m_tlast",  M_AXIS_TLAST, 0);
      chk("rst_m_tdata",  M_AXIS_TDATA, 0);
      chk("rst_state",    state_dbg, 0);
      chk("rst_active",   active_ch_dbg, 0);
      chk("rst_err_short", err_short, 0);
      chk("rst_err_cfg",  err_cfg, 0);
      AXIS_ARESETN = 1'b1;
      tick();

      // Basic packet; inputs change mid-packet and must not affect it
      exp_hdr5(32'h1060_0009, SID0, 32'h11, 64'h2233);
      for (int k = 0; k < 4; k++) ex(32'hC000_0000 + 32'(k), 1'(k == 3));
      ch_enable = 2'b01;
      tick();
      chk("grant_to_hdr", state_dbg, 1);
      chk("grant_ch", active_ch_dbg, 0);
      ch_enable      = 2'b00;
      pkt_size       = 16'd7;
      trailer_en     = 1'b1;
      timestamp_sec  = 32'h99;
      timestamp_fsec = 64'hFFFF;
      stream_id      = '0;
      wait_done("basic_pkt", 200);
      chk("basic_err_short", err_short, 0);

      // Reset pulse between packets restores rotation pointer and counts
      AXIS_ARESETN = 1'b0;
      tick();
      AXIS_ARESETN = 1'b1;
      tick();

      // Both channels continuously valid: ch0,ch1 alternate, counts 0,1,2
      stream_id = {SID1, SID0}; pkt_size = 16'd2; trailer_en = 1'b0;
      timestamp_sec = 32'h11; timestamp_fsec = 64'h2233;
      for (int k = 0; k < 6; k++) begin
         src_q0.push_back({1'(k % 2), 32'hC000_0010 + 32'(k)});
         src_q1.push_back({1'(k % 2), 32'hC100_0010 + 32'(k)});
      end
      for (int k = 0; k < 3; k++) begin
         exp_hdr5(32'h1060_0007 + 32'(k) * 32'h0001_0000, SID0, 32'h11, 64'h2233);
         ex(32'hC000_0010 + 32'(2 * k), 1'b0);
         ex(32'hC000_0011 + 32'(2 * k), 1'b1);
         exp_hdr5(32'h1060_0007 + 32'(k) * 32'h0001_0000, SID1, 32'h11, 64'h2233);
         ex(32'hC100_0010 + 32'(2 * k), 1'b0);
         ex(32'hC100_0011 + 32'(2 * k), 1'b1);
      end
      ch_enable = 2'b11;
      wait_done("rr_alternate", 600);
      ch_enable = 2'b00;

      // Trailer packet
      pkt_size = 16'd3; trailer_en = 1'b1; trailer = 32'hA5A5_A5A5;
      timestamp_sec = 32'h1234_5678; timestamp_fsec = 64'h0000_0001_8000_0000;
      for (int k = 0; k < 3; k++) src_q0.push_back({1'(k == 2), 32'hC000_0020 + 32'(k)});
      exp_hdr5(32'h1463_0009, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      for (int k = 0; k < 3; k++) ex(32'hC000_0020 + 32'(k), 1'b0);
      ex(32'hA5A5_A5A5, 1'b1);
      ch_enable = 2'b01;
      wait_done("trailer_pkt", 200);
      ch_enable = 2'b00;
      chk("trl_err_short", err_short, 0);

      // Short input: early TLAST on word 2, padded with zeros
      pkt_size = 16'd4; trailer_en = 1'b0;
      src_q0.push_back({1'b0, 32'hC000_0030});
      src_q0.push_back({1'b1, 32'hC000_0031});
      exp_hdr5(32'h1064_0009, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      ex(32'hC000_0030, 1'b0);
      ex(32'hC000_0031, 1'b0);
      ex(32'h0, 1'b0);
      ex(32'h0, 1'b1);
      ch_enable = 2'b01;
      wait_done("short_pad", 200);
      ch_enable = 2'b00;
      chk("short_err_set", err_short, 2'b01);
      tick();
      chk("short_err_sticky", err_short, 2'b01);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("short_err_clr", err_short, 0);

      // pkt_size 0: no packet, err_cfg set, error wins over same-cycle clear
      pkt_size = 16'd0;
      src_q0.push_back({1'b1, 32'hC000_0040});
      ch_enable = 2'b01;
      repeat (4) tick();
      chk("cfg_err_set", err_cfg, 1);
      chk("cfg_stay_idle", state_dbg, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("cfg_err_wins", err_cfg, 1);
      exp_hdr5(32'h1065_0006, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      ex(32'hC000_0040, 1'b1);
      pkt_size = 16'd1;
      wait_done("size1_pkt", 200);
      ch_enable = 2'b00;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("cfg_err_clr", err_cfg, 0);

      // Random backpressure, both channels: pointer now favours ch1
      pkt_size = 16'd5; trailer_en = 1'b0; rand_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         src_q1.push_back({1'(k == 4), 32'hC100_0050 + 32'(k)});
         src_q0.push_back({1'(k == 4), 32'hC000_0050 + 32'(k)});
      end
      exp_hdr5(32'h1063_000A, SID1, 32'h1234_5678, 64'h0000_0001_8000_0000);
      for (int k = 0; k < 5; k++) ex(32'hC100_0050 + 32'(k), 1'(k == 4));
      exp_hdr5(32'h1066_000A, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      for (int k = 0; k < 5; k++) ex(32'hC000_0050 + 32'(k), 1'(k == 4));
      ch_enable = 2'b11;
      wait_done("rand_ready", 2000);
      ch_enable = 2'b00;
      rand_rdy = 1'b0;

      // Reset during PAYLOAD aborts; next packet restarts with count 0
      pkt_size = 16'd4;
      src_q0.push_back({1'b0, 32'hC000_0060});
      exp_hdr5(32'h1067_0009, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      ex(32'hC000_0060, 1'b0);
      ch_enable = 2'b01;
      n = 0;
      while (!(exp_q.size() == 0 && state_dbg == 4'd6) && n < 200) begin
         tick();
         n++;
      end
      chk("mid_reached_payload", state_dbg, 6);
      src_q0.push_back({1'b1, 32'hC000_0061});
      stall = 1'b1;
      tick();
      tick();
      chk("mid_passthru_vld", M_AXIS_TVALID, 1);
      chk("mid_passthru_dat", M_AXIS_TDATA, 32'hC000_0061);
      pkt_size = 16'd1;
      AXIS_ARESETN = 1'b0;
      #1;
      chk("mid_rst_vld", M_AXIS_TVALID, 0);
      chk("mid_rst_dat", M_AXIS_TDATA, 0);
      chk("mid_rst_tready", S_AXIS_TREADY, 0);
      chk("mid_rst_state", state_dbg, 0);
      tick();
      stall = 1'b0;
      exp_hdr5(32'h1060_0006, SID0, 32'h1234_5678, 64'h0000_0001_8000_0000);
      ex(32'hC000_0061, 1'b1);
      AXIS_ARESETN = 1'b1;
      wait_done("post_reset_pkt", 200);
      ch_enable = 2'b00;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vita49_pack_mc.md
VITA49_PACK_MC -- requirements
Module: vita49_pack_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of AXIS input channels, range 1-8.
REQ-002 Parameter CNT_W, default 16: payload/packet-size counter width.
REQ-003 AXIS_ACLK  in  1  single clock for all logic.
REQ-004 AXIS_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 S_AXIS_TDATA  in  NUM_CH*32  per-channel payload; channel i at bits [32i+31:32i].
REQ-006 S_AXIS_TVALID / S_AXIS_TLAST  in  NUM_CH each  per-channel valid / last.
REQ-007 S_AXIS_TREADY  out  NUM_CH  per-channel ready.
REQ-008 M_AXIS_TDATA  out  32; M_AXIS_TVALID, M_AXIS_TLAST  out  1; M_AXIS_TREADY  in  1  packet stream.
REQ-009 ch_enable  in  NUM_CH  per-channel enable.
REQ-010 stream_id  in  NUM_CH*32  per-channel VITA49 stream ID.
REQ-011 pkt_size  in  CNT_W  payload words per packet.
REQ-012 trailer_en  in  1  append trailer word; trailer  in  32  trailer value.
REQ-013 timestamp_sec  in  32; timestamp_fsec  in  64  time source.
REQ-014 err_clr  in  1  clears sticky errors.
REQ-015 err_short  out  NUM_CH  sticky: input TLAST before pkt_size words.
REQ-016 err_cfg  out  1  sticky: packet start attempted with pkt_size 0.
REQ-017 state_dbg  out  4  FSM state encoding; active_ch_dbg  out  3  served channel.

Function
REQ-018 FSM states: IDLE, HDR, SID, TSI, TSF_HI, TSF_LO, PAYLOAD, PAD, TRL.
REQ-019 IDLE: channel i requests when ch_enable[i] and S_AXIS_TVALID[i]; round-robin grant, search starts at last-served+1 mod NUM_CH; grant takes one cycle, then HDR.
REQ-020 At grant, latch stream_id[ch], pkt_size, trailer_en, trailer, timestamp_sec, timestamp_fsec; mid-packet input changes do not affect the current packet.
REQ-021 pkt_size 0 at grant: no packet, err_cfg set, stay IDLE, rotation pointer advances.
REQ-022 Header word: [31:28]=0001, [27]=0, [26]=trailer_en, [25:24]=0, [23:22]=01, [21:20]=10, [19:16]=per-channel 4-bit packet count, [15:0]=5+pkt_size+trailer_en, truncated to 16 bits.
REQ-023 Packet count per channel increments mod 16 after its TLAST handshake; starts at 0.
REQ-024 HDR, SID, TSI, TSF_HI, TSF_LO emit header, stream ID, seconds, fsec[63:32], fsec[31:0], one word per M handshake.
REQ-025 PAYLOAD: combinational pass-through; M_AXIS_TDATA/TVALID = granted channel's; granted S_AXIS_TREADY = M_AXIS_TREADY; all others 0.
REQ-026 Payload counter counts handshakes; at pkt_size, exit to TRL if trailer_en, else IDLE; input TLAST at that word ignored.
REQ-027 Input TLAST before pkt_size words: set err_short[ch], enter PAD; PAD emits 0x00000000 until pkt_size reached, S_AXIS_TREADY held 0.
REQ-028 TRL emits latched trailer word.
REQ-029 M_AXIS_TLAST = 1 only on the final word (last payload/pad word, or trailer).
REQ-030 Outside PAYLOAD, M_AXIS_TVALID = 1 in all non-IDLE states; TDATA stable while TVALID and not TREADY.
REQ-031 ch_enable deassert mid-packet: packet completes normally.
REQ-032 err_clr and a new error same cycle: error wins (bit set).

Reset
REQ-033 AXIS_ARESETN low: FSM IDLE, all S_AXIS_TREADY 0, M_AXIS_TVALID 0, M_AXIS_TLAST 0, M_AXIS_TDATA 0, counters 0, packet counts 0, errors 0, rotation pointer to channel 0, debug outputs 0.
REQ-034 Reset asserted mid-packet aborts immediately; no resumption after release.

Structure
REQ-035 Shared package vita49_pkg: FSM state encoding, packet type 0001, TSI 01, TSF 10, header word count 5.
REQ-036 Sub-module vita49_rr_arb (NUM_CH request vector in, one-hot grant out, pointer update on grant).

Verification
REQ-037 NUM_CH=2, pkt_size=4, trailer_en=0, ch0 valid, sec=0x11, fsec=0x22_33 -> header 0x1060_0009, ID, 0x11, 0x0, 0x22_33, 4 payload words, TLAST on word 9.
REQ-038 Both channels continuously valid, pkt_size=2 -> packets alternate ch0,ch1,ch0; each channel's count field 0,1,2.
REQ-039 trailer_en=1, trailer=0xA5A5_A5A5, pkt_size=3 -> size field 9, word 9 = 0xA5A5_A5A5 with TLAST.
REQ-040 pkt_size=4, input TLAST on word 2 -> words 3,4 = 0, err_short[0]=1 until err_clr.
REQ-041 M_AXIS_TREADY random 50 % -> no word lost/duplicated, TDATA stable under stall.
REQ-042 Reset pulsed during PAYLOAD -> outputs 0 next edge, next packet starts with count 0.
